lap_recorder: RTL

LAP_RECORDER -- requirements
Module: lap_recorder

---
 rtl/lap_recorder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lap_recorder.sv
// Lap recorder for a BCD stopwatch: captures split times on lap presses, shows each
// split for a fixed hold time, and keeps up to DEPTH laps for later viewing.
// Optional feature macro: LAP_RECORDER_RECALL_EN enables the RECALL mode that steps
// through stored laps with recall_btn. Without it recall_btn is ignored.
module lap_recorder #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tenths,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic       running,
    input  logic       lap_btn,
    input  logic       recall_btn,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tenths,
    output logic [1:0] mode,
    output logic [3:0] lap_count,
    output logic [2:0] lap_index,
    output logic       full
);

    localparam int unsigned     HoldW    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
    localparam logic [3:0]      DepthCnt = 4'(DEPTH);

    typedef enum logic [1:0] {
        StLive   = 2'b00,
        StSplit  = 2'b01,
        StRecall = 2'b10
    } mode_e;

    mode_e            mode_q;
    logic [3:0]       lap_count_q;
    logic [2:0]       lap_index_q;
    logic             full_q;
    logic [HoldW-1:0] hold_q;
    logic [11:0]      disp_q;

    logic             lap_prev_q;
    // Set when reset releases with the button already down; cleared on release.
    logic             lap_held_q;

    logic [11:0]      live;
    logic             lap_ev;
    logic             capture;

    assign live    = {sec_tens, sec_ones, tenths};
    assign lap_ev  = lap_btn & ~lap_prev_q & ~lap_held_q;
    assign capture = lap_ev & running & ~full_q & (mode_q != StRecall);

    // Lap button edge detector with post-reset hold-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_prev_q <= 1'b0;
            lap_held_q <= lap_btn;
        end else begin
            lap_prev_q <= lap_btn;
            if (!lap_btn) begin
                lap_held_q <= 1'b0;
            end
        end
    end

`ifdef LAP_RECORDER_RECALL_EN
    localparam int unsigned IdxW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic        rec_prev_q;
    logic        rec_held_q;
    logic        recall_ev;
    logic        recall_enter;
    logic        last_entry;
    logic [2:0]  next_idx;
    logic [11:0] mem_q [DEPTH];

    assign recall_ev    = recall_btn & ~rec_prev_q & ~rec_held_q;
    // A capturing lap press wins over a simultaneous recall press.
    assign recall_enter = recall_ev & (mode_q != StRecall) & (lap_count_q != 4'd0) & ~capture;
    assign last_entry   = ({1'b0, lap_index_q} + 4'd1) == lap_count_q;
    assign next_idx     = lap_index_q + 3'd1;

    // Recall button edge detector with post-reset hold-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_prev_q <= 1'b0;
            rec_held_q <= recall_btn;
        end else begin
            rec_prev_q <= recall_btn;
            if (!recall_btn) begin
                rec_held_q <= 1'b0;
            end
        end
    end

    // Lap storage; not cleared on reset since lap_count masks stale entries.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[lap_count_q[IdxW-1:0]] <= live;
        end
    end
`else
    logic unused_recall;
    assign unused_recall = recall_btn;
`endif

    // Mode FSM with registered display, lap counter, index and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= StLive;
            lap_count_q <= 4'd0;
            lap_index_q <= 3'd0;
            full_q      <= 1'b0;
            hold_q      <= '0;
            disp_q      <= 12'd0;
        end else begin
            unique case (mode_q)
                StLive, StSplit: begin
                    if (capture) begin
                        mode_q      <= StSplit;
                        lap_count_q <= lap_count_q + 4'd1;
                        full_q      <= (lap_count_q + 4'd1) == DepthCnt;
                        hold_q      <= HoldLoad;
                        disp_q      <= live;
`ifdef LAP_RECORDER_RECALL_EN
                    end else if (recall_enter) begin
                        mode_q      <= StRecall;
                        lap_index_q <= 3'd0;
                        hold_q      <= '0;
                        disp_q      <= mem_q[0];
`endif
                    end else if ((mode_q == StSplit) && (hold_q != '0)) begin
                        hold_q <= hold_q - HoldW'(1);
                    end else begin
                        // LIVE tracking, or the split hold has just expired.
                        mode_q <= StLive;
                        disp_q <= live;
                    end
                end
`ifdef LAP_RECORDER_RECALL_EN
                StRecall: begin
                    if (recall_ev) begin
                        if (last_entry) begin
                            mode_q      <= StLive;
                            lap_index_q <= 3'd0;
                            disp_q      <= live;
                        end else begin
                            lap_index_q <= next_idx;
                            disp_q      <= mem_q[next_idx[IdxW-1:0]];
                        end
                    end
                end
`endif
                default: begin
                    mode_q      <= StLive;
                    lap_index_q <= 3'd0;
                    disp_q      <= live;
                end
            endcase
        end
    end

    assign disp_tens   = disp_q[11:8];
    assign disp_ones   = disp_q[7:4];
    assign disp_tenths = disp_q[3:0];
    assign mode        = mode_q;
    assign lap_count   = lap_count_q;
    assign lap_index   = lap_index_q;
    assign full        = full_q;

endmodule
